// File: rtl/toy_mem_pkg.sv
// toy_mem_pkg: shared types and constants for the toy memory responder.
//   state_e        - responder FSM states
//   ADDR_W/DATA_W  - address and data widths (8/8)
//   CNT_W          - wait-state counter width
//   PROT_LIMIT_DEF - default lower bound of the writable region
package toy_mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] PROT_LIMIT_DEF = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/toy_mem_if.sv
// toy_mem_if: processor <-> memory pin bundle.
//   master (processor): drives MEM_EN, WRITE_EN, D_OUT; receives D_IN, READY, BUSY, WP_ERR
//   slave  (memory)   : the reverse
interface toy_mem_if;
  import toy_mem_pkg::*;

  logic              MEM_EN;
  logic              WRITE_EN;
  logic [DATA_W-1:0] D_OUT;
  logic [DATA_W-1:0] D_IN;
  logic              READY;
  logic              BUSY;
  logic              WP_ERR;

  modport master (
    output MEM_EN, WRITE_EN, D_OUT,
    input  D_IN, READY, BUSY, WP_ERR
  );

  modport slave (
    input  MEM_EN, WRITE_EN, D_OUT,
    output D_IN, READY, BUSY, WP_ERR
  );

endinterface

// File: rtl/toy_mem_array.sv
// toy_mem_array: 256 x 8 storage, one synchronous write port, one synchronous
// read port whose output register holds until the next read.
//   CLK, RESET         - clock, synchronous active-low reset (read register only)
//   we, waddr, wdata   - write port
//   re, raddr, rdata   - read port; rdata updates on an edge with re=1
module toy_mem_array
  import toy_mem_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset: contents survive RESET.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register doubles as the responder's D_IN holding register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/toy_mem_responder.sv
// toy_mem_responder: memory-side responder for the toy processor.
// Accepts a request (address on D_OUT) in IDLE, takes write data the next
// cycle, waits WAIT_STATES cycles, then pulses READY for one cycle.
//   CLK, RESET - clock, synchronous active-low reset
//   bus        - toy_mem_if.slave (MEM_EN, WRITE_EN, D_OUT -> D_IN, READY, BUSY, WP_ERR)
// Parameters: WAIT_STATES (0..15), PROT_LIMIT.
// Optional macro TOY_MEM_WRITE_PROTECT_EN: writes below PROT_LIMIT are dropped
// and flagged with WP_ERR alongside READY; otherwise WP_ERR stays 0.
module toy_mem_responder
  import toy_mem_pkg::*;
#(
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] PROT_LIMIT  = PROT_LIMIT_DEF
) (
  input  logic CLK,
  input  logic RESET,
  toy_mem_if.slave bus
);

`ifdef TOY_MEM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  localparam bit               HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, busy_q, wp_err_q;

  logic              prot_c;
  logic              we_c;
  logic              re_c;
  logic [ADDR_W-1:0] raddr_c;
  logic [DATA_W-1:0] rdata;

  // Latched address falls in the protected region (always 0 without the macro).
  assign prot_c = WP_EN && (addr_q < PROT_LIMIT);

  // Next-state, counter and array-port control.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    we_c    = 1'b0;
    raddr_c = addr_q;
    case (state_q)
      ST_IDLE: begin
        // Zero-wait reads go straight to RESP, so read the bus address directly.
        raddr_c = bus.D_OUT;
        if (bus.MEM_EN) begin
          addr_d = bus.D_OUT;
          wr_d   = bus.WRITE_EN;
          if (bus.WRITE_EN) begin
            state_d = ST_WDATA;
          end else if (HAS_WAIT) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WDATA: begin
        // Gated by RESET so a write caught by reset is discarded.
        we_c = RESET && !prot_c;
        if (HAS_WAIT) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // RESP is only ever entered, never held, so this fires once per read.
    re_c = RESET && (state_d == ST_RESP) && !wr_d;
  end

  // State, request latches and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      wp_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      ready_q  <= (state_d == ST_RESP);
      busy_q   <= (state_d != ST_IDLE);
      wp_err_q <= (state_d == ST_RESP) && wr_d && prot_c;
    end
  end

  toy_mem_array u_array (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (we_c),
    .waddr (addr_q),
    .wdata (bus.D_OUT),
    .re    (re_c),
    .raddr (raddr_c),
    .rdata (rdata)
  );

  assign bus.D_IN   = rdata;
  assign bus.READY  = ready_q;
  assign bus.BUSY   = busy_q;
  assign bus.WP_ERR = wp_err_q;

endmodule

// File: tb/tb_toy_mem_responder.sv
// tb_toy_mem_responder: scoreboard bench for toy_mem_responder.
// Main DUT uses WAIT_STATES=1 with random traffic; a second DUT with
// WAIT_STATES=0 covers the zero-wait boundary. Honours TOY_MEM_WRITE_PROTECT_EN.
// Timing note: a registered output "at edge e" is the value the processor
// samples at edge e, i.e. it is visible at the negedge where cyc == e-1.
module tb_toy_mem_responder;
  import toy_mem_pkg::*;

  localparam int WS = 1;
  localparam int P  = WS + 2;

`ifdef TOY_MEM_WRITE_PROTECT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  toy_mem_if bus ();
  toy_mem_if bus0 ();

  toy_mem_responder #(.WAIT_STATES(WS), .PROT_LIMIT(8'h40)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  toy_mem_responder #(.WAIT_STATES(0), .PROT_LIMIT(8'h40)) dut0 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus0.slave)
  );

  // Reference model: memory image, which locations hold known data, last read.
  typedef struct {
    int         ready_cyc;
    logic [7:0] d_in;
    logic       wp;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [256];
  bit         valid [256];
  logic [7:0] wlist[$];
  logic [7:0] last_rd = 8'h00;

  function automatic bit is_prot(input logic [7:0] a);
    return PROT_ON && (a < 8'h40);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive a request at a negedge in IDLE and push its expected response.
  task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int   k;
    k = cyc + 1;
    bus.MEM_EN   = 1'b1;
    bus.WRITE_EN = w;
    bus.D_OUT    = a;
    if (w) begin
      e.wp = is_prot(a);
      if (!e.wp) begin
        if (!valid[a]) wlist.push_back(a);
        valid[a]   = 1'b1;
        ref_mem[a] = d;
      end
      e.d_in      = last_rd;
      e.ready_cyc = k + 1 + WS;
    end else begin
      e.wp        = 1'b0;
      last_rd     = ref_mem[a];
      e.d_in      = last_rd;
      e.ready_cyc = k + WS;
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.READY !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (bus.READY !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: READY not seen within 40 cycles (cyc %0d)", cyc);
    end
  endtask

  // One complete processor transfer; returns at a negedge with the DUT in IDLE.
  task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d);
    issue(w, a, d);
    @(negedge CLK);
    bus.MEM_EN   = 1'b0;
    bus.WRITE_EN = 1'b0;
    bus.D_OUT    = w ? d : 8'($urandom);
    wait_ready();
    @(negedge CLK);
  endtask

  // Monitor: every READY pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (bus.READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: READY=1 with nothing outstanding (cyc %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("ready_cycle", cyc, e.ready_cyc);
        chk("d_in", bus.D_IN, e.d_in);
        chk("wp_err", bus.WP_ERR, e.wp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         cnt;
    int         c;
    logic [7:0] ra;
    logic [7:0] old;

    bus.MEM_EN  = 1'b0; bus.WRITE_EN  = 1'b0; bus.D_OUT  = 8'h00;
    bus0.MEM_EN = 1'b0; bus0.WRITE_EN = 1'b0; bus0.D_OUT = 8'h00;

    // Reset for two edges.
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", bus.READY, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_d_in", bus.D_IN, 8'h00);
    chk("rst_wp_err", bus.WP_ERR, 1'b0);
    chk("rst_d_in_ws0", bus0.D_IN, 8'h00);
    RESET = 1'b1;

    // No requests: stays idle.
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.BUSY !== 1'b0 || bus.READY !== 1'b0) cnt++;
    end
    chk("idle_quiet", cnt, 0);

    // Directed transfers, including the top address and the protection boundary.
    xfer(1'b1, 8'h80, 8'h5A);
    xfer(1'b0, 8'h80, 8'h00);
    xfer(1'b1, 8'hFF, 8'hC3);
    xfer(1'b0, 8'hFF, 8'h00);
    xfer(1'b1, 8'h10, 8'hAA);
    if (valid[8'h10]) xfer(1'b0, 8'h10, 8'h00);
    xfer(1'b1, 8'h40, 8'hAA);
    xfer(1'b0, 8'h40, 8'h00);
    xfer(1'b1, 8'h3F, 8'h77);

    // Random traffic; reads only target locations with known contents.
    for (int i = 0; i < 80; i++) begin
      bit         w;
      logic [7:0] a;
      w = (wlist.size() == 0) || ($urandom_range(0, 1) == 1);
      if (w) a = 8'($urandom);
      else   a = wlist[$urandom_range(0, wlist.size() - 1)];
      xfer(w, a, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    // Reset while in WDATA: no READY, write discarded, D_IN cleared.
    ra  = wlist[0];
    old = ref_mem[ra];
    bus.MEM_EN = 1'b1; bus.WRITE_EN = 1'b1; bus.D_OUT = ra;
    @(negedge CLK);
    chk("wdata_busy", bus.BUSY, 1'b1);
    bus.MEM_EN = 1'b0; bus.WRITE_EN = 1'b0; bus.D_OUT = ~old;
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_busy", bus.BUSY, 1'b0);
    chk("midrst_ready", bus.READY, 1'b0);
    chk("midrst_d_in", bus.D_IN, 8'h00);
    RESET   = 1'b1;
    last_rd = 8'h00;
    bus.D_OUT = 8'h00;
    @(negedge CLK);
    xfer(1'b0, ra, 8'h00);

    // MEM_EN held high: back-to-back reads of 8'h80, one per P cycles.
    c = cyc;
    bus.MEM_EN = 1'b1; bus.WRITE_EN = 1'b0; bus.D_OUT = 8'h80;
    last_rd = ref_mem[8'h80];
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.ready_cyc = c + 1 + i * P + WS;
      e.d_in      = last_rd;
      e.wp        = 1'b0;
      exp_q.push_back(e);
    end
    cnt = 0;
    repeat (1 + 3 * P) begin
      @(negedge CLK);
      if (bus.BUSY === 1'b0) cnt++;
    end
    bus.MEM_EN = 1'b0;
    chk("held_idle_gaps", cnt, 3);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      @(negedge CLK);
      cnt++;
    end
    chk("drain", exp_q.size(), 0);

    // Zero wait states on the second instance.
    @(negedge CLK);
    bus0.MEM_EN = 1'b1; bus0.WRITE_EN = 1'b1; bus0.D_OUT = 8'hFF;
    @(negedge CLK);
    bus0.MEM_EN = 1'b0; bus0.WRITE_EN = 1'b0; bus0.D_OUT = 8'hC3;
    chk("ws0_wdata_ready", bus0.READY, 1'b0);
    @(negedge CLK);
    chk("ws0_wr_ready", bus0.READY, 1'b1);
    chk("ws0_wr_d_in", bus0.D_IN, 8'h00);
    @(negedge CLK);
    bus0.MEM_EN = 1'b1; bus0.WRITE_EN = 1'b0; bus0.D_OUT = 8'hFF;
    @(negedge CLK);
    chk("ws0_rd_ready", bus0.READY, 1'b1);
    chk("ws0_rd_d_in", bus0.D_IN, 8'hC3);
    @(negedge CLK);
    chk("ws0_gap_ready", bus0.READY, 1'b0);
    chk("ws0_gap_busy", bus0.BUSY, 1'b0);
    @(negedge CLK);
    bus0.MEM_EN = 1'b0;
    chk("ws0_rd2_ready", bus0.READY, 1'b1);
    chk("ws0_rd2_d_in", bus0.D_IN, 8'hC3);
    @(negedge CLK);
    chk("ws0_end_ready", bus0.READY, 1'b0);
    chk("ws0_end_busy", bus0.BUSY, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
